cpu_run_ctrl: RTL and testbench

Execution controller for the 4-bit CPU. Holds the 16x8 program memory that feeds `inst` from `pc`, and generates the one-cycle `cpu_tick` enable that advances the CPU. Supports run at a programmable rate, single-step, stop, a pc breakpoint and self-loop halt detection. Sits between board-level controls (buttons, debug host) and the CPU core.

---
 rtl/cpu_run_ctrl_if.sv | 32 +++
 rtl/cpu_run_ctrl.sv | 138 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_run_ctrl_if.sv
// Bus between the CPU execution controller and its surroundings: run/stop/step
// commands, program-load port, breakpoint setup and the CPU-facing pc/inst/tick.
interface cpu_run_ctrl_if #(parameter int DIV_W = 24);
  logic             cmd_run;
  logic             cmd_stop;
  logic             cmd_step;
  logic [DIV_W-1:0] div;
  logic             prog_we;
  logic [3:0]       prog_addr;
  logic [7:0]       prog_data;
  logic             prog_ack;
  logic             bp_en;
  logic [3:0]       bp_addr;
  logic [3:0]       pc;
  logic [7:0]       inst;
  logic             cpu_tick;
  logic [1:0]       state;
  logic             halted;
  logic [7:0]       tick_count;

  modport master (
    output cmd_run, cmd_stop, cmd_step, div, prog_we, prog_addr, prog_data,
           bp_en, bp_addr, pc,
    input  prog_ack, inst, cpu_tick, state, halted, tick_count
  );

  modport slave (
    input  cmd_run, cmd_stop, cmd_step, div, prog_we, prog_addr, prog_data,
           bp_en, bp_addr, pc,
    output prog_ack, inst, cpu_tick, state, halted, tick_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution controller for the 4-bit CPU: program memory, tick generation, step/halt/breakpoint.
// Define CPU_RUN_CTRL_BP_EN to build the pc breakpoint logic.
//
// state | meaning
// STOP  | idle; program memory writable
// RUN   | free-running, one tick every div+1 cycles
// STEP  | one tick, then post-tick check, then back to STOP
// HALT  | self-loop detected; only cmd_stop leaves
module cpu_run_ctrl #(
  parameter int DIV_W = 24
) (
  input logic           clk_cpu_i,
  input logic           reset_i,
  cpu_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [3:0]       pc_prev_q, pc_prev_d;
  logic             chk_q;
  logic [7:0]       tick_count_q;
  logic             prog_ack_q;
  logic [7:0]       mem_q [16];

  logic tick;
  logic halt_hit;
  logic bp_hit;
  logic wr_ok;

  // chk_q marks the cycle right after a tick, when the CPU has moved to its new pc
  assign halt_hit = chk_q && (bus.pc == pc_prev_q);

`ifdef CPU_RUN_CTRL_BP_EN
  assign bp_hit = chk_q && bus.bp_en && (bus.pc == bus.bp_addr);
`else
  logic unused_bp;
  assign unused_bp = ^{bus.bp_en, bus.bp_addr};
  assign bp_hit    = 1'b0;
`endif

  assign wr_ok = bus.prog_we && (state_q == ST_STOP);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tick    = 1'b0;
    case (state_q)
      ST_STOP: begin
        if (bus.cmd_stop) begin
          state_d = ST_STOP;
        end else if (bus.cmd_step) begin
          state_d = ST_STEP;
        end else if (bus.cmd_run) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        if (bus.cmd_stop) begin
          state_d = ST_STOP;
        end else if (halt_hit) begin
          state_d = ST_HALT;
        end else if (bp_hit) begin
          state_d = ST_STOP;
        end else if (presc_q >= bus.div) begin
          // a div lowered below the running count wraps without ticking
          presc_d = '0;
          tick    = (presc_q == bus.div);
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      ST_STEP: begin
        if (bus.cmd_stop) begin
          state_d = ST_STOP;
        end else if (!chk_q) begin
          tick = 1'b1;
        end else if (halt_hit) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_STOP;
        end
      end
      ST_HALT: begin
        if (bus.cmd_stop) begin
          state_d = ST_STOP;
        end
      end
      default: state_d = ST_STOP;
    endcase
    if (reset_i) begin
      tick = 1'b0;
    end
  end

  assign pc_prev_d = tick ? bus.pc : pc_prev_q;

  always_ff @(posedge clk_cpu_i) begin
    if (reset_i) begin
      state_q      <= ST_STOP;
      presc_q      <= '0;
      pc_prev_q    <= 4'd0;
      chk_q        <= 1'b0;
      tick_count_q <= 8'd0;
      prog_ack_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      pc_prev_q  <= pc_prev_d;
      chk_q      <= tick;
      prog_ack_q <= wr_ok;
      if (tick && (tick_count_q != 8'hFF)) begin
        tick_count_q <= tick_count_q + 1'b1;
      end
      if (wr_ok) begin
        mem_q[bus.prog_addr] <= bus.prog_data;
      end
    end
  end

  assign bus.inst       = mem_q[bus.pc];
  assign bus.cpu_tick   = tick;
  assign bus.state      = state_q;
  assign bus.halted     = (state_q == ST_HALT);
  assign bus.tick_count = tick_count_q;
  assign bus.prog_ack   = prog_ack_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: a toy CPU (opcode F = jump to low nibble, else pc+1) plus
// cycle-indexed tick log; expected tick cycles come from the div+1 period arithmetic.
module tb_cpu_run_ctrl;
  localparam int DIV_W = 24;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.DIV_W(DIV_W)) bus ();
  cpu_run_ctrl #(.DIV_W(DIV_W)) dut (.clk_cpu_i(clk), .reset_i(rst), .bus(bus));

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         tick_q[$];
  logic [7:0] prog_m [16];
  logic       pc_set = 1'b0;
  logic [3:0] pc_set_val = 4'd0;

  // cycle n lies between posedge n and posedge n+1; a tick is logged with its cycle index
  always @(posedge clk) begin
    if (bus.cpu_tick) tick_q.push_back(cyc);
    cyc <= cyc + 1;
    if (pc_set) bus.pc <= pc_set_val;
    else if (rst) bus.pc <= 4'd0;
    else if (bus.cpu_tick) bus.pc <= (bus.inst[7:4] == 4'hF) ? bus.inst[3:0] : bus.pc + 4'd1;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus.cmd_run = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_step = 1'b0;
    bus.prog_we = 1'b0; bus.bp_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) prog_m[i] = 8'h00;
  endtask

  task automatic set_pc(input logic [3:0] v);
    @(negedge clk); pc_set = 1'b1; pc_set_val = v;
    @(negedge clk); pc_set = 1'b0;
  endtask

  task automatic load_rand();
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      d = 8'($urandom_range(0, 255));
      if (d[7:4] == 4'hF) d[7:4] = 4'hE;
      prog_m[i] = d;
      @(negedge clk); bus.prog_we = 1'b1; bus.prog_addr = 4'(i); bus.prog_data = d;
    end
    @(negedge clk); bus.prog_we = 1'b0;
  endtask

  task automatic write_one(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); bus.prog_we = 1'b1; bus.prog_addr = a; bus.prog_data = d;
    @(negedge clk); bus.prog_we = 1'b0;
    prog_m[a] = d;
  endtask

  task automatic pulse_run(output int c);
    @(negedge clk); bus.cmd_run = 1'b1; c = cyc;
    @(negedge clk); bus.cmd_run = 1'b0;
  endtask

  task automatic pulse_stop();
    @(negedge clk); bus.cmd_stop = 1'b1;
    @(negedge clk); bus.cmd_stop = 1'b0;
  endtask

  task automatic pulse_step();
    @(negedge clk); bus.cmd_step = 1'b1;
    @(negedge clk); bus.cmd_step = 1'b0;
  endtask

  task automatic wait_ticks(input int n, input int budget, output bit ok);
    while (tick_q.size() < n && budget > 0) begin
      @(negedge clk); budget--;
    end
    ok = (tick_q.size() >= n);
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output bit ok);
    while (bus.state !== st && budget > 0) begin
      @(negedge clk); budget--;
    end
    ok = (bus.state === st);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    total++; if (bus.cpu_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", bus.cpu_tick); end
    total++; if (bus.prog_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus.prog_ack); end
    total++; if (bus.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
    total++; if (bus.tick_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.tick_count); end
    for (int a = 0; a < 16; a++) begin
      set_pc(4'(a));
      total++; if (bus.inst !== 8'h00) begin bad++; $display("FAIL reset_mem[%0d] got=%h exp=00", a, bus.inst); end
    end
  endtask

  task automatic test_load_step();
    int base;
    do_reset();
    load_rand();
    for (int k = 0; k < 2; k++) begin
      logic [7:0] d;
      d = (k == 0) ? 8'hA1 : 8'hB2;
      @(negedge clk); bus.prog_we = 1'b1; bus.prog_addr = 4'(k); bus.prog_data = d;
      @(negedge clk); bus.prog_we = 1'b0; prog_m[k] = d;
      total++; if (bus.prog_ack !== 1'b1) begin bad++; $display("FAIL load_ack%0d got=%b exp=1", k, bus.prog_ack); end
      @(negedge clk);
      total++; if (bus.prog_ack !== 1'b0) begin bad++; $display("FAIL load_ack_once%0d got=%b exp=0", k, bus.prog_ack); end
    end
    set_pc(4'd0);
    total++; if (bus.inst !== prog_m[0]) begin bad++; $display("FAIL load_inst0 got=%h exp=%h", bus.inst, prog_m[0]); end
    base = tick_q.size();
    pulse_step();
    total++; if (bus.state !== 2'd2 || bus.cpu_tick !== 1'b1) begin bad++; $display("FAIL step_c1 state=%0d tick=%b exp state=2 tick=1", bus.state, bus.cpu_tick); end
    @(negedge clk);
    total++; if (bus.cpu_tick !== 1'b0 || bus.pc !== 4'd1) begin bad++; $display("FAIL step_c2 tick=%b pc=%0d exp tick=0 pc=1", bus.cpu_tick, bus.pc); end
    @(negedge clk);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL step_done got=%0d exp=0", bus.state); end
    total++; if (bus.inst !== prog_m[1]) begin bad++; $display("FAIL step_inst got=%h exp=%h", bus.inst, prog_m[1]); end
    total++; if (bus.tick_count !== 8'd1) begin bad++; $display("FAIL step_count got=%0d exp=1", bus.tick_count); end
    total++; if (tick_q.size() - base != 1) begin bad++; $display("FAIL step_ticks got=%0d exp=1", tick_q.size() - base); end
  endtask

  task automatic test_rate(input int d);
    int c, base, t, nt;
    bit ok;
    nt = 6;
    do_reset();
    load_rand();
    set_pc(4'd0);
    bus.div = DIV_W'(d);
    base = tick_q.size();
    pulse_run(c);
    wait_ticks(base + nt, (d + 1) * nt + 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL rate_timeout div=%0d got=%0d exp=%0d ticks", d, tick_q.size() - base, nt); end
    for (int k = 0; k < nt && base + k < tick_q.size(); k++) begin
      total++; if (tick_q[base + k] != c + (d + 1) * (k + 1)) begin bad++; $display("FAIL rate_tick%0d div=%0d got=%0d exp=%0d", k, d, tick_q[base + k], c + (d + 1) * (k + 1)); end
    end
    t = c + (d + 1) * (nt + 1);
    while (cyc < t) @(negedge clk);
    bus.cmd_stop = 1'b1;
    #1;
    total++; if (bus.cpu_tick !== 1'b0) begin bad++; $display("FAIL rate_stop_tick got=%b exp=0", bus.cpu_tick); end
    @(negedge clk); bus.cmd_stop = 1'b0;
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rate_stop_state got=%0d exp=0", bus.state); end
    total++; if (bus.tick_count !== 8'(nt)) begin bad++; $display("FAIL rate_count got=%0d exp=%0d", bus.tick_count, nt); end
    total++; if (bus.pc !== 4'(nt)) begin bad++; $display("FAIL rate_pc got=%0d exp=%0d", bus.pc, nt); end
    repeat (d + 3) @(negedge clk);
    total++; if (tick_q.size() - base != nt) begin bad++; $display("FAIL rate_after_stop got=%0d exp=%0d", tick_q.size() - base, nt); end
  endtask

  task automatic test_rate_lower();
    int c, base, t;
    bit ok;
    do_reset();
    load_rand();
    set_pc(4'd0);
    bus.div = DIV_W'(5);
    base = tick_q.size();
    pulse_run(c);
    t = c + 6;
    while (cyc < t + 4) @(negedge clk);
    // count is 3 here; dropping div to 1 must wrap silently
    bus.div = DIV_W'(1);
    wait_ticks(base + 4, 20, ok);
    total++; if (!ok) begin bad++; $display("FAIL lower_timeout got=%0d exp=4 ticks", tick_q.size() - base); end
    for (int k = 0; k < 4 && base + k < tick_q.size(); k++) begin
      int e;
      e = (k == 0) ? t : t + 4 + 2 * k;
      total++; if (tick_q[base + k] != e) begin bad++; $display("FAIL lower_tick%0d got=%0d exp=%0d", k, tick_q[base + k], e); end
    end
    pulse_stop();
  endtask

  task automatic test_halt(input int p, input int d);
    int c, base, last;
    bit ok;
    do_reset();
    load_rand();
    write_one(4'(p), {4'hF, 4'(p)});
    set_pc(4'd0);
    bus.div = DIV_W'(d);
    base = tick_q.size();
    last = c;
    pulse_run(c);
    last = c + (d + 1) * (p + 1);
    wait_state(2'd3, (d + 1) * (p + 1) + 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL halt_timeout p=%0d div=%0d state=%0d exp=3", p, d, bus.state); end
    total++; if (bus.halted !== 1'b1) begin bad++; $display("FAIL halt_flag got=%b exp=1", bus.halted); end
    total++; if (bus.tick_count !== 8'(p + 1)) begin bad++; $display("FAIL halt_count got=%0d exp=%0d", bus.tick_count, p + 1); end
    total++; if (bus.pc !== 4'(p)) begin bad++; $display("FAIL halt_pc got=%0d exp=%0d", bus.pc, p); end
    total++; if (tick_q.size() == 0 || tick_q[tick_q.size() - 1] != last) begin bad++; $display("FAIL halt_last_tick got=%0d exp=%0d", (tick_q.size() == 0) ? -1 : tick_q[tick_q.size() - 1], last); end
    repeat (d + 3) @(negedge clk);
    pulse_run(c);
    repeat (3) @(negedge clk);
    pulse_step();
    repeat (3) @(negedge clk);
    total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL halt_ignore_cmds got=%0d exp=3", bus.state); end
    total++; if (tick_q.size() - base != p + 1) begin bad++; $display("FAIL halt_no_more_ticks got=%0d exp=%0d", tick_q.size() - base, p + 1); end
    pulse_stop();
    total++; if (bus.state !== 2'd0 || bus.halted !== 1'b0) begin bad++; $display("FAIL halt_exit state=%0d halted=%b exp 0/0", bus.state, bus.halted); end
  endtask

  task automatic test_breakpoint();
    int c, base, d;
    bit ok;
    do_reset();
    load_rand();
    d = $urandom_range(0, 2);
    bus.bp_en = 1'b1;
    bus.bp_addr = 4'd4;
    bus.div = DIV_W'(d);
    set_pc(4'd0);
    base = tick_q.size();
    pulse_run(c);
`ifdef CPU_RUN_CTRL_BP_EN
    wait_ticks(base + 4, (d + 1) * 4 + 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout got=%0d exp=4 ticks", tick_q.size() - base); end
    repeat ((d + 1) * 2 + 2) @(negedge clk);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL bp_state got=%0d exp=0", bus.state); end
    total++; if (bus.tick_count !== 8'd4) begin bad++; $display("FAIL bp_count got=%0d exp=4", bus.tick_count); end
    total++; if (bus.pc !== 4'd4) begin bad++; $display("FAIL bp_pc got=%0d exp=4", bus.pc); end
    total++; if (tick_q.size() - base != 4) begin bad++; $display("FAIL bp_ticks got=%0d exp=4", tick_q.size() - base); end
`else
    wait_ticks(base + 8, (d + 1) * 8 + 10, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_off_timeout got=%0d exp=8 ticks", tick_q.size() - base); end
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL bp_off_state got=%0d exp=1", bus.state); end
    total++; if (bus.tick_count !== 8'd8) begin bad++; $display("FAIL bp_off_count got=%0d exp=8", bus.tick_count); end
`endif
    pulse_stop();
    bus.bp_en = 1'b0;
  endtask

  task automatic test_writes_outside_stop();
    int c, base, t, a;
    bit ok;
    do_reset();
    load_rand();
    bus.div = DIV_W'(2);
    set_pc(4'd0);
    base = tick_q.size();
    pulse_run(c);
    wait_ticks(base + 2, 20, ok);
    a = $urandom_range(0, 15);
    @(negedge clk); bus.prog_we = 1'b1; bus.prog_addr = 4'(a); bus.prog_data = prog_m[a] ^ 8'h5A;
    @(negedge clk); bus.prog_we = 1'b0;
    total++; if (bus.prog_ack !== 1'b0) begin bad++; $display("FAIL run_write_ack got=%b exp=0", bus.prog_ack); end
    total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL run_write_state got=%0d exp=1", bus.state); end
    pulse_stop();
    set_pc(4'(a));
    total++; if (bus.inst !== prog_m[a]) begin bad++; $display("FAIL run_write_mem[%0d] got=%h exp=%h", a, bus.inst, prog_m[a]); end
    // reset lands on a cycle where a tick is due
    bus.div = DIV_W'(1);
    set_pc(4'd0);
    base = tick_q.size();
    pulse_run(c);
    t = c + 6;
    while (cyc < t) @(negedge clk);
    rst = 1'b1;
    #1;
    total++; if (bus.cpu_tick !== 1'b0) begin bad++; $display("FAIL rst_run_tick got=%b exp=0", bus.cpu_tick); end
    @(negedge clk); rst = 1'b0;
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL rst_run_state got=%0d exp=0", bus.state); end
    total++; if (bus.tick_count !== 8'd0) begin bad++; $display("FAIL rst_run_count got=%0d exp=0", bus.tick_count); end
    total++; if (tick_q.size() - base != 2) begin bad++; $display("FAIL rst_run_ticks got=%0d exp=2", tick_q.size() - base); end
    for (int i = 0; i < 16; i++) prog_m[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      set_pc(4'(i));
      total++; if (bus.inst !== prog_m[i]) begin bad++; $display("FAIL rst_run_mem[%0d] got=%h exp=%h", i, bus.inst, prog_m[i]); end
    end
  endtask

  task automatic test_priority_sat();
    int c, base;
    bit ok;
    do_reset();
    load_rand();
    set_pc(4'd0);
    @(negedge clk); bus.cmd_run = 1'b1; bus.cmd_step = 1'b1;
    @(negedge clk); bus.cmd_run = 1'b0; bus.cmd_step = 1'b0;
    total++; if (bus.state !== 2'd2 || bus.cpu_tick !== 1'b1) begin bad++; $display("FAIL prio_step state=%0d tick=%b exp 2/1", bus.state, bus.cpu_tick); end
    repeat (2) @(negedge clk);
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL prio_step_done got=%0d exp=0", bus.state); end
    @(negedge clk); bus.cmd_run = 1'b1; bus.cmd_stop = 1'b1;
    @(negedge clk); bus.cmd_run = 1'b0; bus.cmd_stop = 1'b0;
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL prio_stop_run got=%0d exp=0", bus.state); end
    bus.div = DIV_W'(0);
    base = tick_q.size();
    pulse_run(c);
    wait_ticks(base + 300, 400, ok);
    total++; if (!ok) begin bad++; $display("FAIL sat_timeout got=%0d exp=300 ticks", tick_q.size() - base); end
    total++; if (bus.tick_count !== 8'd255) begin bad++; $display("FAIL sat_count got=%0d exp=255", bus.tick_count); end
    pulse_stop();
    total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL sat_stop got=%0d exp=0", bus.state); end
  endtask

  initial begin
    rst = 1'b1;
    bus.cmd_run = 1'b0; bus.cmd_stop = 1'b0; bus.cmd_step = 1'b0;
    bus.div = '0; bus.prog_we = 1'b0; bus.prog_addr = 4'd0; bus.prog_data = 8'h00;
    bus.bp_en = 1'b0; bus.bp_addr = 4'd0;
    test_reset();
    test_load_step();
    test_rate(3);
    test_rate($urandom_range(0, 6));
    test_rate_lower();
    test_halt(5, 0);
    test_halt($urandom_range(1, 14), $urandom_range(0, 3));
    test_breakpoint();
    test_writes_outside_stop();
    test_priority_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
